cook_sequencer: RTL and testbench

Top-level sequencer for the microwave oven. It owns keypad digit entry, decides when the min:sec timer is loaded and enabled, and decides when the magnetron runs. It also handles pause/resume, door interlock and the end-of-cook beep. It sits between the front-panel inputs and the timer/magnetron/7-segment datapath, and replaces ad-hoc gating in the top level with one explicit FSM.

---
 rtl/micro_waves_pkg.sv | 20 ++
 rtl/keypad_encoder.sv | 27 ++
 rtl/cook_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_cook_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/micro_waves_pkg.sv
// Shared types and defaults for the microwave oven control path.
package micro_waves_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ENTRY   = 3'd1,
      ST_COOKING = 3'd2,
      ST_PAUSED  = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam int DIGIT_W          = 4;
   localparam int BEEP_TICKS_DEF   = 3;
   localparam int POWER_WINDOW_DEF = 10;

   function automatic logic is_onehot10(input logic [9:0] v);
      return (v != '0) && ((v & (v - 10'd1)) == '0);
   endfunction

endpackage

// File: rtl/keypad_encoder.sv
// One-hot keypad to BCD digit; key_valid pulses only on a clean idle-to-single-key transition.
module keypad_encoder
   import micro_waves_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [9:0]         keyboard,
   output logic               key_valid,
   output logic [DIGIT_W-1:0] key_digit
);

   logic [9:0] r_kb_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_kb_d <= '0;
      else     r_kb_d <= keyboard;
   end

   always_comb begin
      key_digit = '0;
      for (int unsigned k = 0; k < 10; k++)
         if (keyboard[k]) key_digit = DIGIT_W'(k);
   end

   assign key_valid = (r_kb_d == '0) && is_onehot10(keyboard);

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: keypad entry, timer load/enable, magnetron drive, beep.
// Define COOK_POWER_LEVEL_EN to add the power_level port and duty-cycled magnetron drive.
module cook_sequencer
   import micro_waves_pkg::*;
#(
   parameter int BEEP_TICKS   = BEEP_TICKS_DEF,
   parameter int POWER_WINDOW = POWER_WINDOW_DEF
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               startn,
   input  logic               stopn,
   input  logic               clearn,
   input  logic               door_closed,
   input  logic [9:0]         keyboard,
   input  logic               tick_1hz,
   input  logic               timer_zero,
`ifdef COOK_POWER_LEVEL_EN
   input  logic [3:0]         power_level,
`endif
   output logic [DIGIT_W-1:0] load_min,
   output logic [DIGIT_W-1:0] load_tens,
   output logic [DIGIT_W-1:0] load_ones,
   output logic               loadn,
   output logic               timer_en,
   output logic               mag_on,
   output logic               beep,
   output logic [2:0]         state
);

   if (BEEP_TICKS < 1 || BEEP_TICKS > 255 || POWER_WINDOW < 1 || POWER_WINDOW > 16) begin : g_param_check
      $error("cook_sequencer: BEEP_TICKS or POWER_WINDOW out of range");
   end

   state_t             r_state, w_state_nxt;
   logic [DIGIT_W-1:0] r_min, r_tens, r_ones;
   logic [DIGIT_W-1:0] w_min_nxt, w_tens_nxt, w_ones_nxt;
   logic               r_loadn, w_loadn_nxt;
   logic               r_pend, w_pend_nxt;
   logic               r_cook_en, w_cook_nxt;
   logic [7:0]         r_beep_cnt, w_beep_nxt;
   logic               r_start_d, r_stop_d, r_clear_d;
   logic               w_start, w_stop, w_clear, w_start_ok;
   logic               w_key_valid;
   logic [DIGIT_W-1:0] w_key_digit;

   keypad_encoder u_keypad (
      .clk       (clk),
      .rst       (rst),
      .keyboard  (keyboard),
      .key_valid (w_key_valid),
      .key_digit (w_key_digit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_start_d <= 1'b1;
         r_stop_d  <= 1'b1;
         r_clear_d <= 1'b1;
      end else begin
         r_start_d <= startn;
         r_stop_d  <= stopn;
         r_clear_d <= clearn;
      end
   end

   assign w_start = r_start_d & ~startn;
   assign w_stop  = r_stop_d  & ~stopn;
   assign w_clear = r_clear_d & ~clearn;

   // An accepted start spends one cycle in r_pend (timer load slot) before COOKING.
   always_comb begin
      w_state_nxt = r_state;
      w_min_nxt   = r_min;
      w_tens_nxt  = r_tens;
      w_ones_nxt  = r_ones;
      w_loadn_nxt = 1'b1;
      w_pend_nxt  = 1'b0;
      w_beep_nxt  = r_beep_cnt;
      w_start_ok  = door_closed && (r_tens <= DIGIT_W'(5)) &&
                    ((r_state == ST_PAUSED) || ({r_min, r_tens, r_ones} != '0));
      if (w_clear) begin
         w_state_nxt = ST_IDLE;
         w_min_nxt   = '0;
         w_tens_nxt  = '0;
         w_ones_nxt  = '0;
         w_loadn_nxt = 1'b0;
      end else if (r_pend) begin
         if (door_closed) w_state_nxt = ST_COOKING;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_key_valid) begin
                  w_state_nxt = ST_ENTRY;
                  w_min_nxt   = '0;
                  w_tens_nxt  = '0;
                  w_ones_nxt  = w_key_digit;
               end
            end
            ST_ENTRY: begin
               if (w_stop) begin
                  w_state_nxt = ST_IDLE;
                  w_min_nxt   = '0;
                  w_tens_nxt  = '0;
                  w_ones_nxt  = '0;
               end else if (w_start && w_start_ok) begin
                  w_loadn_nxt = 1'b0;
                  w_pend_nxt  = 1'b1;
               end else if (w_key_valid) begin
                  w_min_nxt  = r_tens;
                  w_tens_nxt = r_ones;
                  w_ones_nxt = w_key_digit;
               end
            end
            ST_COOKING: begin
               if (!door_closed)    w_state_nxt = ST_PAUSED;
               else if (timer_zero) begin
                  w_state_nxt = ST_DONE;
                  w_beep_nxt  = '0;
               end else if (w_stop) w_state_nxt = ST_PAUSED;
            end
            ST_PAUSED: begin
               if (w_stop) begin
                  w_state_nxt = ST_IDLE;
                  w_min_nxt   = '0;
                  w_tens_nxt  = '0;
                  w_ones_nxt  = '0;
               end else if (w_start && w_start_ok) begin
                  w_pend_nxt = 1'b1;
               end
            end
            ST_DONE: begin
               if (w_key_valid) begin
                  w_state_nxt = ST_ENTRY;
                  w_min_nxt   = '0;
                  w_tens_nxt  = '0;
                  w_ones_nxt  = w_key_digit;
               end else if (tick_1hz) begin
                  if (r_beep_cnt == 8'(BEEP_TICKS - 1)) w_state_nxt = ST_IDLE;
                  else                                  w_beep_nxt  = r_beep_cnt + 8'd1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

`ifdef COOK_POWER_LEVEL_EN
   localparam int WIN_W = (POWER_WINDOW > 1) ? $clog2(POWER_WINDOW) : 1;
   logic [WIN_W-1:0] r_win, w_win_nxt;
   logic [3:0]       w_power_p;

   always_comb begin
      w_power_p = (power_level == 4'd0 || power_level > 4'd10) ? 4'd10 : power_level;
      w_win_nxt = r_win;
      if (!w_clear && r_pend && door_closed && r_state == ST_ENTRY)
         w_win_nxt = '0;
      else if (r_state == ST_COOKING && tick_1hz)
         w_win_nxt = (r_win == WIN_W'(POWER_WINDOW - 1)) ? '0 : r_win + 1'b1;
      w_cook_nxt = (w_state_nxt == ST_COOKING) && (32'(w_win_nxt) < 32'(w_power_p));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_win <= '0;
      else     r_win <= w_win_nxt;
   end
`else
   assign w_cook_nxt = (w_state_nxt == ST_COOKING);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_min      <= '0;
         r_tens     <= '0;
         r_ones     <= '0;
         r_loadn    <= 1'b1;
         r_pend     <= 1'b0;
         r_cook_en  <= 1'b0;
         r_beep_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_min      <= w_min_nxt;
         r_tens     <= w_tens_nxt;
         r_ones     <= w_ones_nxt;
         r_loadn    <= w_loadn_nxt;
         r_pend     <= w_pend_nxt;
         r_cook_en  <= w_cook_nxt;
         r_beep_cnt <= w_beep_nxt;
      end
   end

   assign state     = r_state;
   assign load_min  = r_min;
   assign load_tens = r_tens;
   assign load_ones = r_ones;
   assign loadn     = r_loadn;
   assign timer_en  = (r_state == ST_COOKING);
   // Door gating stays combinational so opening the door cuts the magnetron with no latency.
   assign mag_on    = r_cook_en & door_closed;
   assign beep      = (r_state == ST_DONE);

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer: entry/start, pause/resume, done/beep, rejects, clear, reset.
module tb_cook_sequencer;
   import micro_waves_pkg::*;

   logic       clk = 1'b0, rst = 1'b0;
   logic       startn = 1'b1, stopn = 1'b1, clearn = 1'b1, door_closed = 1'b1;
   logic       tick_1hz = 1'b0, timer_zero = 1'b0;
   logic [9:0] keyboard = '0;
   logic [3:0] load_min, load_tens, load_ones;
   logic       loadn, timer_en, mag_on, beep;
   logic [2:0] state;
`ifdef COOK_POWER_LEVEL_EN
   logic [3:0] power_level = 4'd10;
`endif
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   cook_sequencer #(.BEEP_TICKS(3), .POWER_WINDOW(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .startn      (startn),
      .stopn       (stopn),
      .clearn      (clearn),
      .door_closed (door_closed),
      .keyboard    (keyboard),
      .tick_1hz    (tick_1hz),
      .timer_zero  (timer_zero),
`ifdef COOK_POWER_LEVEL_EN
      .power_level (power_level),
`endif
      .load_min    (load_min),
      .load_tens   (load_tens),
      .load_ones   (load_ones),
      .loadn       (loadn),
      .timer_en    (timer_en),
      .mag_on      (mag_on),
      .beep        (beep),
      .state       (state)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic key(input int d);
      keyboard = '0;
      keyboard[d] = 1'b1;
      step(1);
      keyboard = '0;
      step(1);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step(2);
      total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
      total++; if (loadn !== 1'b1) begin bad++; $display("FAIL rst_loadn got=%0b exp=1", loadn); end
      total++; if ({timer_en, mag_on, beep} !== 3'b000) begin bad++; $display("FAIL rst_outs got=%b exp=000", {timer_en, mag_on, beep}); end
      total++; if ({load_min, load_tens, load_ones} !== 12'h000) begin bad++; $display("FAIL rst_digits got=%h exp=000", {load_min, load_tens, load_ones}); end
      rst = 1'b0;
      step(1);
   endtask

   task automatic test_entry_start;
      key(1); key(3); key(0);
      total++; if (state !== 3'd1) begin bad++; $display("FAIL entry_state got=%0d exp=1", state); end
      total++; if ({load_min, load_tens, load_ones} !== 12'h130) begin bad++; $display("FAIL entry_digits got=%h exp=130", {load_min, load_tens, load_ones}); end
      startn = 1'b0;
      step(1);
      total++; if (loadn !== 1'b0) begin bad++; $display("FAIL start_loadn_low got=%0b exp=0", loadn); end
      total++; if ({load_min, load_tens, load_ones} !== 12'h130) begin bad++; $display("FAIL start_load_val got=%h exp=130", {load_min, load_tens, load_ones}); end
      total++; if ({timer_en, mag_on} !== 2'b00) begin bad++; $display("FAIL start_n1_en got=%b exp=00", {timer_en, mag_on}); end
      startn = 1'b1;
      step(1);
      total++; if (loadn !== 1'b1) begin bad++; $display("FAIL start_loadn_one_cycle got=%0b exp=1", loadn); end
      total++; if (state !== 3'd2) begin bad++; $display("FAIL start_cooking got=%0d exp=2", state); end
      total++; if ({timer_en, mag_on} !== 2'b11) begin bad++; $display("FAIL start_n2_en got=%b exp=11", {timer_en, mag_on}); end
   endtask

   task automatic test_door_pause;
      door_closed = 1'b0;
      #1;
      total++; if (mag_on !== 1'b0) begin bad++; $display("FAIL door_mag_comb got=%0b exp=0", mag_on); end
      total++; if (state !== 3'd2) begin bad++; $display("FAIL door_state_same got=%0d exp=2", state); end
      step(1);
      total++; if (state !== 3'd3) begin bad++; $display("FAIL door_paused got=%0d exp=3", state); end
      total++; if (timer_en !== 1'b0) begin bad++; $display("FAIL door_timer_en got=%0b exp=0", timer_en); end
      door_closed = 1'b1;
      step(1);
      total++; if (mag_on !== 1'b0) begin bad++; $display("FAIL paused_mag got=%0b exp=0", mag_on); end
      startn = 1'b0;
      step(1);
      total++; if (loadn !== 1'b1) begin bad++; $display("FAIL resume_noload1 got=%0b exp=1", loadn); end
      startn = 1'b1;
      step(1);
      total++; if (loadn !== 1'b1) begin bad++; $display("FAIL resume_noload2 got=%0b exp=1", loadn); end
      total++; if (state !== 3'd2) begin bad++; $display("FAIL resume_state got=%0d exp=2", state); end
      total++; if (mag_on !== 1'b1) begin bad++; $display("FAIL resume_mag got=%0b exp=1", mag_on); end
   endtask

   task automatic test_done_beep;
      timer_zero = 1'b1;
      step(1);
      timer_zero = 1'b0;
      total++; if (state !== 3'd4) begin bad++; $display("FAIL done_state got=%0d exp=4", state); end
      total++; if ({timer_en, mag_on, beep} !== 3'b001) begin bad++; $display("FAIL done_outs got=%b exp=001", {timer_en, mag_on, beep}); end
      for (int i = 1; i <= 3; i++) begin
         step(2);
         tick_1hz = 1'b1;
         step(1);
         tick_1hz = 1'b0;
         total++; if (beep !== (i < 3)) begin bad++; $display("FAIL beep_tick%0d got=%0b exp=%0b", i, beep, (i < 3)); end
         total++; if (state !== ((i < 3) ? 3'd4 : 3'd0)) begin bad++; $display("FAIL beep_state%0d got=%0d exp=%0d", i, state, (i < 3) ? 4 : 0); end
      end
   endtask

   task automatic test_rejects;
      key(0);
      total++; if ({state, load_min, load_tens, load_ones} !== {3'd1, 12'h000}) begin bad++; $display("FAIL zero_entry got=%h exp=1000", {state, load_min, load_tens, load_ones}); end
      startn = 1'b0; step(1);
      total++; if (loadn !== 1'b1) begin bad++; $display("FAIL zero_noload got=%0b exp=1", loadn); end
      startn = 1'b1; step(1);
      total++; if (state !== 3'd1) begin bad++; $display("FAIL zero_stay got=%0d exp=1", state); end
      key(7); key(0);
      total++; if ({load_min, load_tens, load_ones} !== 12'h070) begin bad++; $display("FAIL tens7_digits got=%h exp=070", {load_min, load_tens, load_ones}); end
      startn = 1'b0; step(1);
      total++; if (loadn !== 1'b1) begin bad++; $display("FAIL tens7_noload got=%0b exp=1", loadn); end
      startn = 1'b1; step(1);
      total++; if (state !== 3'd1) begin bad++; $display("FAIL tens7_stay got=%0d exp=1", state); end
      key(5);
      door_closed = 1'b0;
      startn = 1'b0; step(1);
      startn = 1'b1; step(1);
      total++; if ({state, loadn} !== {3'd1, 1'b1}) begin bad++; $display("FAIL door_reject got=%b exp=0011", {state, loadn}); end
      door_closed = 1'b1;
      keyboard = 10'b00_0000_0011; step(1);
      keyboard = '0; step(1);
      total++; if ({load_min, load_tens, load_ones} !== 12'h705) begin bad++; $display("FAIL multikey got=%h exp=705", {load_min, load_tens, load_ones}); end
      keyboard = '0; keyboard[4] = 1'b1; step(3);
      keyboard = '0; step(1);
      total++; if ({load_min, load_tens, load_ones} !== 12'h054) begin bad++; $display("FAIL heldkey got=%h exp=054", {load_min, load_tens, load_ones}); end
      stopn = 1'b0; step(1);
      stopn = 1'b1;
      total++; if ({state, load_min, load_tens, load_ones} !== {3'd0, 12'h000}) begin bad++; $display("FAIL entry_stop got=%h exp=0000", {state, load_min, load_tens, load_ones}); end
      step(1);
   endtask

   task automatic test_clear_stop;
      key(2); key(5); key(9);
      startn = 1'b0; step(1);
      total++; if ({loadn, load_min, load_tens, load_ones} !== {1'b0, 12'h259}) begin bad++; $display("FAIL tens5_load got=%h exp=0259", {loadn, load_min, load_tens, load_ones}); end
      startn = 1'b1; step(1);
      total++; if (state !== 3'd2) begin bad++; $display("FAIL tens5_cook got=%0d exp=2", state); end
      clearn = 1'b0; stopn = 1'b0; step(1);
      clearn = 1'b1; stopn = 1'b1;
      total++; if (state !== 3'd0) begin bad++; $display("FAIL clr_state got=%0d exp=0", state); end
      total++; if ({loadn, load_min, load_tens, load_ones} !== {1'b0, 12'h000}) begin bad++; $display("FAIL clr_load got=%h exp=0000", {loadn, load_min, load_tens, load_ones}); end
      total++; if ({mag_on, timer_en} !== 2'b00) begin bad++; $display("FAIL clr_mag got=%b exp=00", {mag_on, timer_en}); end
      step(1);
      total++; if (loadn !== 1'b1) begin bad++; $display("FAIL clr_loadn_end got=%0b exp=1", loadn); end
   endtask

   task automatic test_async_reset;
      key(1);
      startn = 1'b0; step(1);
      startn = 1'b1; step(1);
      total++; if (mag_on !== 1'b1) begin bad++; $display("FAIL ar_precook got=%0b exp=1", mag_on); end
      rst = 1'b1;
      #1;
      total++; if ({state, mag_on, timer_en} !== {3'd0, 2'b00}) begin bad++; $display("FAIL ar_async got=%b exp=00000", {state, mag_on, timer_en}); end
      #1 rst = 1'b0;
      step(1);
   endtask

`ifdef COOK_POWER_LEVEL_EN
   task automatic test_power;
      power_level = 4'd3;
      key(1);
      startn = 1'b0; step(1);
      startn = 1'b1; step(1);
      total++; if (mag_on !== 1'b1) begin bad++; $display("FAIL pw_w0 got=%0b exp=1", mag_on); end
      for (int k = 1; k <= 11; k++) begin
         tick_1hz = 1'b1; step(1);
         tick_1hz = 1'b0; step(1);
         total++; if (mag_on !== ((k % 10) < 3)) begin bad++; $display("FAIL pw_tick%0d got=%0b exp=%0b", k, mag_on, ((k % 10) < 3)); end
      end
      stopn = 1'b0; step(1);
      stopn = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick_1hz = 1'b1; step(1);
         tick_1hz = 1'b0; step(1);
      end
      startn = 1'b0; step(1);
      startn = 1'b1; step(1);
      total++; if ({state, mag_on} !== {3'd2, 1'b1}) begin bad++; $display("FAIL pw_resume got=%b exp=0101", {state, mag_on}); end
      for (int k = 2; k <= 3; k++) begin
         tick_1hz = 1'b1; step(1);
         tick_1hz = 1'b0; step(1);
         total++; if (mag_on !== (k < 3)) begin bad++; $display("FAIL pw_hold%0d got=%0b exp=%0b", k, mag_on, (k < 3)); end
      end
      clearn = 1'b0; step(1);
      clearn = 1'b1; step(1);
      power_level = 4'd10;
   endtask
`endif

   initial begin
      test_reset();
      test_entry_start();
      test_door_pause();
      test_done_beep();
      test_rejects();
      test_clear_stop();
      test_async_reset();
`ifdef COOK_POWER_LEVEL_EN
      test_power();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
